// File: rtl/uart_tx_fifo.sv
// 8N1 UART transmitter fed by a valid/ready byte FIFO; frames are sent back to back
// while bytes are queued, and txd idles high.
module uart_tx_fifo #(
    parameter int CLK_FREQ   = 100_000_000,
    parameter int BAUD       = 115200,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic [7:0]                         tx_data,
    input  logic                               tx_valid,
    output logic                               tx_ready,
    output logic                               txd,
    output logic                               busy,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]    fifo_count
);
    localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int BW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] DEPTH_C    = CW'(FIFO_DEPTH);
    localparam logic [BW-1:0] LAST_CLK_C = BW'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } state_t;

    logic [7:0]    mem_r [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_r;
    logic [AW-1:0] rd_ptr_r;
    logic [CW-1:0] count_r;
    state_t        state_r;
    state_t        state_next_s;
    logic [BW-1:0] clk_cnt_r;
    logic [BW-1:0] clk_cnt_next_s;
    logic [2:0]    idx_r;
    logic [2:0]    idx_next_s;
    logic [7:0]    shift_r;
    logic [7:0]    shift_next_s;
    logic          txd_r;
    logic          txd_next_s;
    logic          push_s;
    logic          pop_s;
    logic          nonempty_s;
    logic          bit_done_s;

    assign nonempty_s = (count_r != {CW{1'b0}});
    assign bit_done_s = (clk_cnt_r == LAST_CLK_C);
    assign tx_ready   = !rst && (count_r < DEPTH_C);
    assign push_s     = tx_valid && tx_ready;
    assign fifo_count = count_r;
    assign txd        = txd_r;
    assign busy       = (state_r != ST_IDLE) || nonempty_s;

    // FIFO storage; only written on an accepted handshake
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_r[wr_ptr_r] <= tx_data;
        end
    end

    // FIFO pointers and occupancy
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            count_r  <= {CW{1'b0}};
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + AW'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1);
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + CW'(1);
                2'b01:   count_r <= count_r - CW'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    // Serialiser state; txd is registered from the next state so it changes with it
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r   <= ST_IDLE;
            clk_cnt_r <= {BW{1'b0}};
            idx_r     <= 3'd0;
            shift_r   <= 8'h00;
            txd_r     <= 1'b1;
        end else begin
            state_r   <= state_next_s;
            clk_cnt_r <= clk_cnt_next_s;
            idx_r     <= idx_next_s;
            shift_r   <= shift_next_s;
            txd_r     <= txd_next_s;
        end
    end

    // Next-state logic; a pop in IDLE or at the end of STOP loads the next byte
    always_comb begin
        state_next_s   = state_r;
        clk_cnt_next_s = clk_cnt_r;
        idx_next_s     = idx_r;
        shift_next_s   = shift_r;
        pop_s          = 1'b0;
        case (state_r)
            ST_IDLE: begin
                clk_cnt_next_s = {BW{1'b0}};
                if (nonempty_s) begin
                    pop_s        = 1'b1;
                    shift_next_s = mem_r[rd_ptr_r];
                    state_next_s = ST_START;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_START: begin
                if (bit_done_s) begin
                    clk_cnt_next_s = {BW{1'b0}};
                    idx_next_s     = 3'd0;
                    state_next_s   = ST_DATA;
                end else begin
                    clk_cnt_next_s = clk_cnt_r + BW'(1);
                end
            end
            ST_DATA: begin
                if (bit_done_s) begin
                    clk_cnt_next_s = {BW{1'b0}};
                    shift_next_s   = {1'b0, shift_r[7:1]};
                    if (idx_r == 3'd7) begin
                        state_next_s = ST_STOP;
                    end else begin
                        idx_next_s = idx_r + 3'd1;
                    end
                end else begin
                    clk_cnt_next_s = clk_cnt_r + BW'(1);
                end
            end
            ST_STOP: begin
                if (bit_done_s) begin
                    clk_cnt_next_s = {BW{1'b0}};
                    if (nonempty_s) begin
                        pop_s        = 1'b1;
                        shift_next_s = mem_r[rd_ptr_r];
                        state_next_s = ST_START;
                    end else begin
                        state_next_s = ST_IDLE;
                    end
                end else begin
                    clk_cnt_next_s = clk_cnt_r + BW'(1);
                end
            end
            default: begin
                state_next_s   = ST_IDLE;
                clk_cnt_next_s = {BW{1'b0}};
            end
        endcase

        case (state_next_s)
            ST_START: txd_next_s = 1'b0;
            ST_DATA:  txd_next_s = shift_next_s[0];
            default:  txd_next_s = 1'b1;
        endcase
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo at 10 clocks per bit: per-cycle waveform vectors,
// an independent line decoder, and hand sequences for fill, overlap, reset and stall.
module tb_uart_tx_fifo;
    localparam int CPB = 10;
    localparam int FRAME = 10 * CPB;

    typedef struct {
        logic [7:0] data;
        logic [9:0] seq;   // line levels in transmit order, MSB first
    } vec_t;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic       txd;
    logic       busy;
    logic [3:0] fifo_count;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    logic [7:0] rx_q[$];
    logic       rx_ok[$];
    int         rx_t[$];

    bit         mon_active = 1'b0;
    int         mon_off    = 0;
    int         mon_start  = 0;
    bit         mon_good   = 1'b0;
    logic [7:0] mon_byte   = 8'h00;

    vec_t vecs[6];
    vec_t vec_3c;

    uart_tx_fifo #(
        .CLK_FREQ   (1000),
        .BAUD       (100),
        .FIFO_DEPTH (8)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .tx_data    (tx_data),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready),
        .txd        (txd),
        .busy       (busy),
        .fifo_count (fifo_count)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Line decoder: mid-bit sampling of every frame, recording byte, framing and start cycle
    always @(posedge clk) begin
        #1;
        if (rst) begin
            mon_active = 1'b0;
        end else begin
            if (mon_active) begin
                mon_off++;
            end else if (txd === 1'b0) begin
                mon_active = 1'b1;
                mon_off    = 0;
                mon_start  = cyc;
                mon_good   = 1'b1;
            end
            if (mon_active) begin
                if (mon_off % CPB == CPB / 2) begin
                    if (mon_off / CPB == 0) begin
                        mon_good = mon_good && (txd === 1'b0);
                    end else if (mon_off / CPB <= 8) begin
                        mon_byte[mon_off / CPB - 1] = txd;
                    end else begin
                        mon_good = mon_good && (txd === 1'b1);
                    end
                end
                if (mon_off == FRAME - 1) begin
                    rx_q.push_back(mon_byte);
                    rx_ok.push_back(mon_good);
                    rx_t.push_back(mon_start);
                    mon_active = 1'b0;
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_rx();
        rx_q.delete();
        rx_ok.delete();
        rx_t.delete();
    endtask

    task automatic wait_idle(input int budget);
        int n;
        n = 0;
        while (busy !== 1'b0 && n < budget) begin
            tick();
            n++;
        end
        check("idle reached within budget", {31'd0, busy}, 32'd0);
        tick();
        tick();
    endtask

    task automatic check_rx(input string name, input logic [7:0] exp_q[$]);
        check({name, " frame count"}, rx_q.size(), exp_q.size());
        if (rx_q.size() == exp_q.size()) begin
            for (int i = 0; i < exp_q.size(); i++) begin
                check($sformatf("%s byte %0d", name, i), {24'd0, rx_q[i]}, {24'd0, exp_q[i]});
                check($sformatf("%s framing %0d", name, i), {31'd0, rx_ok[i]}, 32'd1);
            end
        end
    endtask

    // One byte from IDLE with an empty FIFO, checked every cycle of its frame
    task automatic run_vector(input vec_t v);
        logic [7:0] exp_q[$];
        clear_rx();
        tx_data  = v.data;
        tx_valid = 1'b1;
        tick();
        check("accept count", {28'd0, fifo_count}, 32'd1);
        check("idle txd before pop", {31'd0, txd}, 32'd1);
        tx_valid = 1'b0;
        tick();
        check("count after pop", {28'd0, fifo_count}, 32'd0);
        for (int c = 0; c < FRAME; c++) begin
            check($sformatf("txd %02h cycle %0d", v.data, c), {31'd0, txd}, {31'd0, v.seq[9 - c / CPB]});
            if (c == FRAME - 1) begin
                check("busy on last stop cycle", {31'd0, busy}, 32'd1);
            end
            tick();
        end
        check("busy after frame", {31'd0, busy}, 32'd0);
        check("txd after frame", {31'd0, txd}, 32'd1);
        tick();
        exp_q = '{v.data};
        check_rx($sformatf("vector %02h", v.data), exp_q);
    endtask

    initial begin
        logic [7:0] exp_q[$];
        int nxt;
        int t0;
        int t_last;
        int t_ready;
        int n_stall;
        bit acc;

        vecs[0] = '{8'hA5, 10'b0101001011};
        vecs[1] = '{8'h00, 10'b0000000001};
        vecs[2] = '{8'hFF, 10'b0111111111};
        vecs[3] = '{8'h01, 10'b0100000001};
        vecs[4] = '{8'h80, 10'b0000000011};
        vecs[5] = '{8'h4E, 10'b0011100101};
        vec_3c  = '{8'h3C, 10'b0001111001};

        rst      = 1'b0;
        tx_valid = 1'b0;
        tx_data  = 8'h00;
        #1 rst = 1'b1;
        tick();
        tick();
        tick();
        check("reset txd", {31'd0, txd}, 32'd1);
        check("reset busy", {31'd0, busy}, 32'd0);
        check("reset count", {28'd0, fifo_count}, 32'd0);
        check("reset tx_ready", {31'd0, tx_ready}, 32'd0);
        rst = 1'b0;
        #1;
        check("tx_ready after release", {31'd0, tx_ready}, 32'd1);
        tick();

        // Asynchronous reset while a frame is on the line and a byte is queued
        tx_valid = 1'b1;
        tx_data  = 8'hAA;
        tick();
        tx_data  = 8'h55;
        tick();
        tx_valid = 1'b0;
        tick();
        tick();
        tick();
        check("pre-reset txd start bit", {31'd0, txd}, 32'd0);
        check("pre-reset count", {28'd0, fifo_count}, 32'd1);
        #2 rst = 1'b1;
        #1;
        check("async reset txd", {31'd0, txd}, 32'd1);
        check("async reset busy", {31'd0, busy}, 32'd0);
        check("async reset count", {28'd0, fifo_count}, 32'd0);
        check("async reset tx_ready", {31'd0, tx_ready}, 32'd0);
        tick();
        tick();
        rst = 1'b0;
        #1;
        check("tx_ready first cycle after reset", {31'd0, tx_ready}, 32'd1);
        tick();
        check("no frame after reset", {31'd0, busy}, 32'd0);

        foreach (vecs[i]) begin
            run_vector(vecs[i]);
        end

        // Fill: nine accepted back to back, then the tenth waits for the second pop
        clear_rx();
        tx_valid = 1'b1;
        nxt = 0;
        t0 = 0;
        t_last = 0;
        for (int i = 0; i < 30 && nxt < 9; i++) begin
            tx_data = nxt[7:0];
            acc = tx_ready;
            tick();
            if (acc) begin
                if (nxt == 0) t0 = cyc;
                t_last = cyc;
                nxt++;
            end
        end
        check("fill accepted", nxt, 9);
        check("fill consecutive", t_last - t0, 8);
        check("fill count full", {28'd0, fifo_count}, 32'd8);
        check("fill tx_ready low", {31'd0, tx_ready}, 32'd0);
        tx_data = 8'h09;
        t_ready = 0;
        for (int i = 0; i < 200; i++) begin
            acc = tx_ready;
            if (acc) t_ready = cyc;
            tick();
            if (acc) break;
        end
        check("fill ready on second pop", t_ready - t0, 101);
        tx_valid = 1'b0;
        wait_idle(1500);
        exp_q = '{8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08, 8'h09};
        check_rx("fill", exp_q);
        if (rx_t.size() == 10) begin
            check("fill first start", rx_t[0] - t0, 1);
            for (int i = 0; i < 9; i++) begin
                check($sformatf("fill gap %0d", i), rx_t[i + 1] - rx_t[i], FRAME);
            end
        end

        // Push lands on the same edge as the STOP pop
        clear_rx();
        tx_valid = 1'b1;
        tx_data = 8'h11;
        tick();
        t0 = cyc;
        tx_data = 8'h22;
        tick();
        tx_data = 8'h33;
        tick();
        tx_data = 8'h44;
        tick();
        tx_valid = 1'b0;
        check("overlap count before", {28'd0, fifo_count}, 32'd3);
        for (int i = 0; i < 200 && cyc < t0 + 100; i++) tick();
        tx_valid = 1'b1;
        tx_data = 8'h55;
        tick();
        tx_valid = 1'b0;
        check("overlap count held", {28'd0, fifo_count}, 32'd3);
        check("overlap next start bit", {31'd0, txd}, 32'd0);
        wait_idle(800);
        exp_q = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
        check_rx("overlap", exp_q);

        // Reset during data bit 4 with five bytes queued
        clear_rx();
        tx_valid = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tx_data = 8'h61 + 8'(i);
            tick();
            if (i == 0) t0 = cyc;
        end
        tx_valid = 1'b0;
        check("midframe queued", {28'd0, fifo_count}, 32'd5);
        for (int i = 0; i < 200 && cyc < t0 + 1 + 55; i++) tick();
        check("midframe data bit 4 of 61", {31'd0, txd}, 32'd0);
        #2 rst = 1'b1;
        #1;
        check("midframe reset txd", {31'd0, txd}, 32'd1);
        check("midframe reset count", {28'd0, fifo_count}, 32'd0);
        check("midframe reset busy", {31'd0, busy}, 32'd0);
        tick();
        rst = 1'b0;
        tick();
        run_vector(vec_3c);
        for (int i = 0; i < 30; i++) tick();
        check("midframe nothing after 3c", rx_q.size(), 1);
        check("midframe idle after 3c", {31'd0, busy}, 32'd0);

        // Producer stalled on a full FIFO with changing data
        clear_rx();
        tx_valid = 1'b1;
        for (int i = 0; i < 9; i++) begin
            tx_data = 8'hB0 + 8'(i);
            tick();
        end
        check("stall full", {28'd0, fifo_count}, 32'd8);
        n_stall = 0;
        for (int i = 0; i < 200; i++) begin
            if (tx_ready) begin
                check("stall count at ready", {28'd0, fifo_count}, 32'd7);
                tx_data = 8'hD7;
                tick();
                break;
            end else begin
                tx_data = 8'hE0 + 8'(i % 16);
                tick();
                n_stall++;
            end
        end
        tx_valid = 1'b0;
        check("stall cycles", n_stall, 93);
        wait_idle(1500);
        exp_q = '{8'hB0, 8'hB1, 8'hB2, 8'hB3, 8'hB4, 8'hB5, 8'hB6, 8'hB7, 8'hB8, 8'hD7};
        check_rx("stall", exp_q);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
